// File: rtl/mem8x8_pkg.sv
// rtl/mem8x8_pkg.sv - shared types and constants for the 8x8 memory arbiter
package mem8x8_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  // Controller states; encoding is fixed so busy/debug taps stay stable.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Requester indices: port 0 is Wishbone-side, port 1 is mprj_io pin-side.
  localparam logic PORT_WB = 1'b0;
  localparam logic PORT_IO = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, state held by the parent
module rr_arb2
  import mem8x8_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  // On a tie the port that did not win last time is granted; a lone request always wins.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        if (last_grant == PORT_IO) begin
          grant[PORT_WB] = 1'b1;
        end else begin
          grant[PORT_IO] = 1'b1;
        end
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/mem8x8_arbiter.sv
// rtl/mem8x8_arbiter.sv - round-robin access sequencer for the 8x8 user memory
module mem8x8_arbiter
  import mem8x8_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Counter covers RD_LAT up to 4 (loaded with RD_LAT-1).
  localparam int             CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [1:0]          arb_grant;

  rr_arb2 u_rr_arb2 (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .en         (state_q == IDLE),
    .grant      (arb_grant)
  );

  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

  // Next-state and strobe decode; fields are latched only at grant so later changes are ignored.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    req0_ack     = 1'b0;
    req1_ack     = 1'b0;
    busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          grant_d      = arb_grant[PORT_IO];
          last_grant_d = arb_grant[PORT_IO];
          if (arb_grant[PORT_IO]) begin
            we_d    = req1_we;
            addr_d  = req1_addr;
            wdata_d = req1_wdata;
          end else begin
            we_d    = req0_we;
            addr_d  = req0_addr;
            wdata_d = req0_wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr = addr_q;
        if (we_q) begin
          mem_wr_en = 1'b1;
          mem_wdata = wdata_q;
          state_d   = DONE;
        end else begin
          mem_rd_en = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        mem_addr = addr_q;
        if (cnt_q == '0) begin
          if (grant_q == PORT_IO) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        req0_ack = (grant_q == PORT_WB);
        req1_ack = (grant_q == PORT_IO);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access without an ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_IO;
      grant_q      <= PORT_WB;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// tb/tb_mem8x8_arbiter.sv - scoreboard bench for mem8x8_arbiter
module tb_mem8x8_arbiter;

  localparam int RD_LAT  = 1;
  localparam int RD_LAT3 = 3;

  typedef struct {
    int         port;
    bit         we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         ack_cyc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // main DUT (RD_LAT=1)
  logic [1:0] rv, rwe, rack;
  logic [2:0] ra [2];
  logic [7:0] rwd [2];
  logic [7:0] rrd [2];
  logic       m_rd, m_wr, busy;
  logic [2:0] m_addr;
  logic [7:0] m_wd, m_rdata;

  // second DUT (RD_LAT=3)
  logic [1:0] xv, xwe, xack;
  logic [2:0] xa [2];
  logic [7:0] xwd [2];
  logic [7:0] xrd [2];
  logic       x_rd, x_wr, x_busy;
  logic [2:0] x_addr;
  logic [7:0] x_wd, x_rdata;

  mem8x8_arbiter #(.ADDR_W(3), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req0_valid(rv[0]), .req0_we(rwe[0]), .req0_addr(ra[0]), .req0_wdata(rwd[0]),
    .req0_ack(rack[0]), .req0_rdata(rrd[0]),
    .req1_valid(rv[1]), .req1_we(rwe[1]), .req1_addr(ra[1]), .req1_wdata(rwd[1]),
    .req1_ack(rack[1]), .req1_rdata(rrd[1]),
    .mem_rd_en(m_rd), .mem_wr_en(m_wr), .mem_addr(m_addr), .mem_wdata(m_wd),
    .mem_rdata(m_rdata), .busy(busy)
  );

  mem8x8_arbiter #(.ADDR_W(3), .DATA_W(8), .RD_LAT(RD_LAT3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req0_valid(xv[0]), .req0_we(xwe[0]), .req0_addr(xa[0]), .req0_wdata(xwd[0]),
    .req0_ack(xack[0]), .req0_rdata(xrd[0]),
    .req1_valid(xv[1]), .req1_we(xwe[1]), .req1_addr(xa[1]), .req1_wdata(xwd[1]),
    .req1_ack(xack[1]), .req1_rdata(xrd[1]),
    .mem_rd_en(x_rd), .mem_wr_en(x_wr), .mem_addr(x_addr), .mem_wdata(x_wd),
    .mem_rdata(x_rdata), .busy(x_busy)
  );

  // memory models: read data is nonzero only in the exact cycle RD_LAT after the strobe
  logic [7:0] mem [8];
  logic [7:0] rd_s;
  always @(posedge clk) begin
    if (m_wr) mem[m_addr] <= m_wd;
    rd_s <= m_rd ? mem[m_addr] : 8'h00;
  end
  assign m_rdata = rd_s;

  logic [7:0] mem3 [8];
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    if (x_wr) mem3[x_addr] <= x_wd;
    p3[0] <= x_rd ? mem3[x_addr] : 8'h00;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign x_rdata = p3[2];

  item_t sb[$];
  item_t sb3[$];
  item_t it, it3;
  bit    in_txn = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor for main DUT
  always @(negedge clk) begin
    if (rst) begin
      in_txn = 1'b0;
    end else begin
      chk("strobe_overlap", {31'd0, m_rd & m_wr}, 0);
      if (m_rd || m_wr) begin
        chk("single_strobe", {31'd0, in_txn}, 0);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", sb.size(), 1);
        end else begin
          chk("strobe_we", {31'd0, m_wr}, {31'd0, sb[0].we});
          chk("strobe_addr", {29'd0, m_addr}, {29'd0, sb[0].addr});
          if (m_wr) chk("strobe_wdata", {24'd0, m_wd}, {24'd0, sb[0].wdata});
          if (sb[0].ack_cyc >= 0)
            chk("strobe_cycle", cyc, sb[0].ack_cyc - (sb[0].we ? 1 : 1 + RD_LAT));
        end
        in_txn = 1'b1;
      end
      if (in_txn) chk("busy_mid_txn", {31'd0, busy}, 1);
      if (!busy) begin
        chk("idle_addr", {29'd0, m_addr}, 0);
        chk("idle_wdata", {24'd0, m_wd}, 0);
      end
      if (|rack) begin
        chk("ack_onehot", {30'd0, rack}, (rack[1] ? 2 : 1));
        chk("done_addr", {29'd0, m_addr}, 0);
        chk("done_wdata", {24'd0, m_wd}, 0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", sb.size(), 1);
        end else begin
          it = sb.pop_front();
          chk("ack_port", {31'd0, rack[1]}, it.port);
          if (!it.we) chk("ack_rdata", {24'd0, rrd[it.port]}, {24'd0, it.rdata});
          if (it.ack_cyc >= 0) chk("ack_cycle", cyc, it.ack_cyc);
        end
        in_txn = 1'b0;
      end
    end
  end

  // monitor for RD_LAT=3 DUT
  always @(negedge clk) begin
    if (!rst) begin
      chk("l3_strobe_overlap", {31'd0, x_rd & x_wr}, 0);
      if (x_rd || x_wr) begin
        if (sb3.size() == 0) chk("l3_unexpected_strobe", sb3.size(), 1);
        else chk("l3_strobe_cycle", cyc, sb3[0].ack_cyc - (sb3[0].we ? 1 : 1 + RD_LAT3));
      end
      if (|xack) begin
        if (sb3.size() == 0) begin
          chk("l3_unexpected_ack", sb3.size(), 1);
        end else begin
          it3 = sb3.pop_front();
          chk("l3_ack_port", {31'd0, xack[1]}, it3.port);
          if (!it3.we) chk("l3_ack_rdata", {24'd0, xrd[it3.port]}, {24'd0, it3.rdata});
          chk("l3_ack_cycle", cyc, it3.ack_cyc);
        end
      end
    end
  end

  task automatic drive(input int p, input bit v, input bit we, input logic [2:0] a, input logic [7:0] wd);
    rv[p] = v; rwe[p] = we; ra[p] = a; rwd[p] = wd;
  endtask

  task automatic wait_ack(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rack[p] !== 1'b1 && n < 40);
    chk("ack_seen", {31'd0, rack[p]}, 1);
    @(posedge clk); #1;
    rv[p] = 1'b0;
  endtask

  task automatic single(input int p, input bit we, input logic [2:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd);
    @(posedge clk); #1;
    sb.push_back('{port: p, we: we, addr: a, wdata: wd, rdata: exp_rd,
                   ack_cyc: cyc + (we ? 2 : 2 + RD_LAT)});
    drive(p, 1'b1, we, a, wd);
    wait_ack(p);
  endtask

  task automatic contend(input int n, input logic [2:0] a0, input logic [7:0] d0,
                         input logic [2:0] a1, input logic [7:0] d1);
    int   cnt [2];
    bit   acked [2];
    int   guard;
    cnt   = '{0, 0};
    guard = 0;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{port: 0, we: 1'b1, addr: 3'(a0 + k), wdata: 8'(d0 + k), rdata: 8'h00, ack_cyc: -1});
      sb.push_back('{port: 1, we: 1'b1, addr: 3'(a1 + k), wdata: 8'(d1 + k), rdata: 8'h00, ack_cyc: -1});
    end
    drive(0, 1'b1, 1'b1, a0, d0);
    drive(1, 1'b1, 1'b1, a1, d1);
    while ((cnt[0] < n || cnt[1] < n) && guard < 50 * n) begin
      @(negedge clk);
      guard++;
      for (int p = 0; p < 2; p++) begin
        acked[p] = (rack[p] === 1'b1);
        if (acked[p]) cnt[p]++;
      end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (acked[p]) begin
          if (cnt[p] < n)
            drive(p, 1'b1, 1'b1, 3'((p == 0 ? a0 : a1) + cnt[p]), 8'((p == 0 ? d0 : d1) + cnt[p]));
          else
            rv[p] = 1'b0;
        end
      end
    end
    chk("contend_done", cnt[0] + cnt[1], 2 * n);
  endtask

  task automatic l3_single(input int p, input bit we, input logic [2:0] a, input logic [7:0] wd,
                           input logic [7:0] exp_rd);
    int n = 0;
    @(posedge clk); #1;
    sb3.push_back('{port: p, we: we, addr: a, wdata: wd, rdata: exp_rd,
                    ack_cyc: cyc + (we ? 2 : 2 + RD_LAT3)});
    xv[p] = 1'b1; xwe[p] = we; xa[p] = a; xwd[p] = wd;
    do begin
      @(negedge clk);
      n++;
    end while (xack[p] !== 1'b1 && n < 40);
    chk("l3_ack_seen", {31'd0, xack[p]}, 1);
    @(posedge clk); #1;
    xv[p] = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_ack"}, {30'd0, rack}, 0);
    chk({tag, "_rd"}, {31'd0, m_rd}, 0);
    chk({tag, "_wr"}, {31'd0, m_wr}, 0);
    chk({tag, "_addr"}, {29'd0, m_addr}, 0);
    chk({tag, "_wdata"}, {24'd0, m_wd}, 0);
    chk({tag, "_rdata0"}, {24'd0, rrd[0]}, 0);
    chk({tag, "_rdata1"}, {24'd0, rrd[1]}, 0);
  endtask

  initial begin
    rv = 2'b00; rwe = 2'b00; ra = '{3'd0, 3'd0}; rwd = '{8'd0, 8'd0};
    xv = 2'b00; xwe = 2'b00; xa = '{3'd0, 3'd0}; xwd = '{8'd0, 8'd0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    chk("reset_l3_busy", {31'd0, x_busy}, 0);

    // writes from each port, then separate reads back
    single(0, 1'b1, 3'd1, 8'hFA, 8'h00);
    single(1, 1'b1, 3'd3, 8'hEA, 8'h00);
    single(0, 1'b0, 3'd1, 8'h00, 8'hFA);
    single(1, 1'b0, 3'd3, 8'h00, 8'hEA);

    // simultaneous writes: port 0 first, then port 1; read back
    contend(1, 3'd5, 8'h11, 3'd6, 8'h22);
    single(0, 1'b0, 3'd5, 8'h00, 8'h11);
    single(1, 1'b0, 3'd6, 8'h00, 8'h22);

    // sustained contention: grants alternate 0,1,0,1,...
    contend(4, 3'd0, 8'hA0, 3'd4, 8'hB0);
    single(0, 1'b0, 3'd3, 8'h00, 8'hA3);
    single(1, 1'b0, 3'd7, 8'h00, 8'hB3);

    // longer read latency instance
    l3_single(0, 1'b1, 3'd3, 8'hEA, 8'h00);
    l3_single(1, 1'b0, 3'd3, 8'h00, 8'hEA);

    // reset during WAIT of a port 0 read
    @(posedge clk); #1;
    sb.push_back('{port: 0, we: 1'b0, addr: 3'd3, wdata: 8'h00, rdata: 8'hA3, ack_cyc: -1});
    drive(0, 1'b1, 1'b0, 3'd3, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    rv  = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_quiet("abort");
    contend(1, 3'd2, 8'h33, 3'd7, 8'h44);
    single(0, 1'b0, 3'd2, 8'h00, 8'h33);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("sb3_drained", sb3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
